// File: rtl/wb_host_master.sv
`default_nettype none
// ============================================================================
// Module      : wb_host_master
// Description : Single-outstanding Wishbone classic initiator. Accepts one
//               command on a valid/ready port, runs one single-beat bus
//               cycle with a wait timeout, and returns read data / write
//               completion plus an error flag on a valid/ready response port.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_host_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  // command port
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [3:0]  cmd_sel_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  // response port
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  // Wishbone initiator
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  // status
  output logic        busy_o,
  output logic [7:0]  err_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Wait-counter value seen in the last permitted strobe cycle.
  localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic        w_accept;
  logic        w_done_ack;
  logic        w_done_timeout;

  logic [15:0] r_wait_cnt;
  logic        r_cyc_stb;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_adr;
  logic [31:0] r_wdat;
  logic        r_cmd_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_dat;
  logic        r_rsp_err;
  logic        r_busy;
  logic [7:0]  r_err_count;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; ack has priority over the timeout in the same cycle.
  always_comb begin
    w_next_state   = r_state;
    w_accept       = 1'b0;
    w_done_ack     = 1'b0;
    w_done_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          w_accept     = 1'b1;
          w_next_state = ST_BUS;
        end
      end
      ST_BUS: begin
        if (wbm_ack_i) begin
          w_done_ack   = 1'b1;
          w_next_state = ST_RESP;
        end else if (r_wait_cnt == c_timeout_last) begin
          w_done_timeout = 1'b1;
          w_next_state   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Bus, response and status registers; every output comes straight from a flop.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_wait_cnt  <= 16'd0;
      r_cyc_stb   <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= 4'd0;
      r_adr       <= 32'd0;
      r_wdat      <= 32'd0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= 32'd0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      r_cmd_ready <= (w_next_state == ST_IDLE);
      r_rsp_valid <= (w_next_state == ST_RESP);
      r_busy      <= (w_next_state != ST_IDLE);

      if (w_accept) begin
        r_we       <= cmd_we_i;
        r_sel      <= cmd_sel_i;
        r_adr      <= cmd_adr_i;
        r_wdat     <= cmd_dat_i;
        r_cyc_stb  <= 1'b1;
        r_wait_cnt <= 16'd0;
      end else if (w_done_ack) begin
        r_cyc_stb <= 1'b0;
        r_rsp_dat <= r_we ? 32'd0 : wbm_dat_i;
        r_rsp_err <= 1'b0;
      end else if (w_done_timeout) begin
        r_cyc_stb <= 1'b0;
        r_rsp_dat <= 32'd0;
        r_rsp_err <= 1'b1;
        if (r_err_count != 8'hFF) begin
          r_err_count <= r_err_count + 8'd1;
        end
      end else if (r_state == ST_BUS) begin
        r_wait_cnt <= r_wait_cnt + 16'd1;
      end
    end
  end

  assign cmd_ready_o = r_cmd_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_dat_o   = r_rsp_dat;
  assign rsp_err_o   = r_rsp_err;
  assign wbm_cyc_o   = r_cyc_stb;
  assign wbm_stb_o   = r_cyc_stb;
  assign wbm_we_o    = r_we;
  assign wbm_sel_o   = r_sel;
  assign wbm_adr_o   = r_adr;
  assign wbm_dat_o   = r_wdat;
  assign busy_o      = r_busy;
  assign err_count_o = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_host_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_host_master
// Description : Self-checking bench for wb_host_master: vector table of bus
//               transactions with a response scoreboard, plus hand-written
//               backpressure, mid-cycle reset and error-count saturation runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_host_master;

  localparam int c_to = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_adr, cmd_dat;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we, ack, busy;
  logic [3:0]  sel;
  logic [31:0] adr, wdat, rdat;
  logic [7:0]  err_count;

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    int          waits;    // ack after this many wait states; -1 = never
    logic [31:0] rdata;    // value the slave drives with ack
    logic [31:0] exp_dat;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   model_errs = 0;

  always #5 clk = ~clk;

  wb_host_master #(.TIMEOUT_CYCLES(c_to)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_sel_i   (cmd_sel),
    .cmd_adr_i   (cmd_adr),
    .cmd_dat_i   (cmd_dat),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .wbm_cyc_o   (cyc),
    .wbm_stb_o   (stb),
    .wbm_we_o    (we),
    .wbm_sel_o   (sel),
    .wbm_adr_o   (adr),
    .wbm_dat_o   (wdat),
    .wbm_ack_i   (ack),
    .wbm_dat_i   (rdat),
    .busy_o      (busy),
    .err_count_o (err_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_timeout();
    if (model_errs < 255) model_errs++;
  endtask

  // Wait (bounded) for cmd_ready, then present a command for one cycle.
  task automatic issue(input vec_t v);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_we    = v.we;
    cmd_sel   = v.sel;
    cmd_adr   = v.adr;
    cmd_dat   = v.dat;
    sb.push_back('{dat: v.exp_dat, err: v.exp_err});
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_adr   = 32'hFFFF_FFFF;
    cmd_dat   = 32'hFFFF_FFFF;
    cmd_sel   = 4'h0;
  endtask

  // Act as the slave while cyc/stb are high; returns the strobe cycle count.
  task automatic serve(input vec_t v, output int stb_cycles);
    int field_errs = 0;
    stb_cycles = 0;
    chk("cyc_after_hs", {31'd0, cyc}, 32'd1);
    chk("ready_low_in_bus", {31'd0, cmd_ready}, 32'd0);
    chk("busy_in_bus", {31'd0, busy}, 32'd1);
    while (cyc && stb_cycles < 300) begin
      if (stb !== 1'b1 || adr !== v.adr || sel !== v.sel || we !== v.we) field_errs++;
      if (v.we && wdat !== v.dat) field_errs++;
      ack  = (v.waits >= 0 && stb_cycles == v.waits);
      rdat = ack ? v.rdata : 32'hDEAD_BEEF;
      @(negedge clk);
      stb_cycles++;
    end
    ack = 1'b0;
    chk("bus_fields_stable", field_errs, 0);
  endtask

  task automatic check_rsp();
    rsp_t e;
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rsp_dat", rsp_dat, e.dat);
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
    end else begin
      chk("sb_underflow", 32'd1, {31'd0, rsp_valid} - 32'd1);
    end
    chk("err_count", {24'd0, err_count}, model_errs);
  endtask

  task automatic run_txn(input vec_t v);
    int n;
    int exp_cycles;
    issue(v);
    serve(v, n);
    exp_cycles = (v.waits >= 0 && v.waits < c_to) ? v.waits + 1 : c_to;
    chk("stb_cycles", n, exp_cycles);
    if (v.exp_err) model_timeout();
    check_rsp();
    @(negedge clk);
    chk("ready_after_rsp", {31'd0, cmd_ready}, 32'd1);
    chk("rsp_valid_clear", {31'd0, rsp_valid}, 32'd0);
  endtask

  vec_t vecs[8];
  vec_t v;
  int   n;
  logic [31:0] held_dat;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_5A5A,  0, 32'hFFFF_FFFF, 32'h0,         1'b0};
    vecs[1] = '{1'b0, 4'hF, 32'h3000_0008, 32'h0,          5, 32'h1234_5678, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b0, 4'hF, 32'h3000_000C, 32'h0,         -1, 32'h0,         32'h0,         1'b1};
    vecs[3] = '{1'b0, 4'hF, 32'h3000_0010, 32'h0,   c_to - 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
    vecs[4] = '{1'b1, 4'h3, 32'h3000_0014, 32'h0BAD_0BAD, c_to - 1, 32'h1111_1111, 32'h0, 1'b0};
    vecs[5] = '{1'b0, 4'h3, 32'h3000_0018, 32'h0,          0, 32'h0000_BEEF, 32'h0000_BEEF, 1'b0};
    vecs[6] = '{1'b1, 4'hC, 32'h3000_001C, 32'h7777_0000, -1, 32'h0,         32'h0,         1'b1};
    vecs[7] = '{1'b0, 4'hF, 32'h3000_0020, 32'h0,          2, 32'h8000_0001, 32'h8000_0001, 1'b0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = 4'h0;
    cmd_adr = 32'h0; cmd_dat = 32'h0; rsp_ready = 1'b1; ack = 1'b0; rdat = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_cyc", {30'd0, cyc, stb}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_dat", rsp_dat, 32'd0);
    chk("rst_busy_err", {30'd0, busy, rsp_err}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    chk("rst_wbm_adr", adr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Backpressure: response held for 10 cycles, stray ack and new command ignored.
    rsp_ready = 1'b0;
    v = '{1'b0, 4'hF, 32'h3000_0040, 32'h0, 1, 32'hAA55_00FF, 32'hAA55_00FF, 1'b0};
    issue(v);
    serve(v, n);
    chk("bp_stb_cycles", n, 2);
    held_dat = 32'hAA55_00FF;
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_dat", rsp_dat, held_dat);
      chk("bp_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("bp_no_cyc", {31'd0, cyc}, 32'd0);
      ack  = (i == 3);
      rdat = 32'h1357_9BDF;
      if (i == 5) begin
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0050; cmd_sel = 4'hF;
      end
      if (i == 8) cmd_valid = 1'b0;
      @(negedge clk);
    end
    ack = 1'b0;
    check_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, cmd_ready}, 32'd1);
    chk("bp_release_cyc", {31'd0, cyc}, 32'd0);

    // Reset during wait state 2: cyc/stb must fall before the next edge.
    v = '{1'b0, 4'hF, 32'h3000_0060, 32'h0, -1, 32'h0, 32'h0, 1'b0};
    issue(v);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_cyc", {31'd0, cyc}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_cyc", {30'd0, cyc, stb}, 32'd0);
    sb.delete();
    model_errs = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
      chk("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("post_rst_err_count", {24'd0, err_count}, 32'd0);
    end

    // Saturation: 256 timeouts leave the counter at 255.
    v = '{1'b1, 4'hF, 32'h3000_0070, 32'h1, -1, 32'h0, 32'h0, 1'b1};
    for (int i = 0; i < 256; i++) run_txn(v);
    chk("sat_err_count", {24'd0, err_count}, 32'd255);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
